// File: rtl/p19_nanov_sequencer.sv
// Bit-serial instruction sequencer for a nanoV-style core: runs 32-clock passes
// per instruction and brackets loads/stores with a memory wait/shift phase.
module p19_nanov_sequencer (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       instr_valid_i,
    input  logic [4:0] instr_op_i,
    input  logic [2:0] instr_f3_i,
    input  logic [4:0] instr_rs1_i,
    input  logic       instr_b25_i,
    input  logic       mem_ack_i,
    output logic       instr_ready_o,
    output logic [4:0] counter_o,
    output logic [2:0] cycle_o,
    output logic       mem_req_o,
    output logic       mem_is_store_o,
    output logic       shift_data_out_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_EXEC      = 2'd1,
        S_MEM_WAIT  = 2'd2,
        S_MEM_SHIFT = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] counter_q, counter_d;
    logic [2:0] cycle_q, cycle_d;
    logic [4:0] op_q, op_d;
    logic [2:0] f3_q, f3_d;
    logic [4:0] rs1_q, rs1_d;
    logic       b25_q, b25_d;

    logic       is_store, is_load, is_fast, is_slow;
    logic       is_mul, is_alu, is_shift, is_jump, is_branch;
    logic [2:0] last_cycle;
    logic       last_beat;
    logic       mem_due;
    logic       new_is_fast;
    logic       take_next;

    // Decode of the captured instruction; these fields only move on acceptance.
    assign is_store  = (op_q == 5'b01000);
    assign is_load   = (op_q == 5'b00000);
    assign is_fast   = is_load && (rs1_q == 5'b00100);
    assign is_slow   = is_load && !is_fast;
    assign is_mul    = (op_q == 5'b01100) && b25_q;
    assign is_alu    = (op_q[2:0] == 3'b100) && !is_mul;
    assign is_shift  = (f3_q == 3'b001) || (f3_q == 3'b101);
    assign is_jump   = (op_q[4:3] == 2'b11) && op_q[0];
    assign is_branch = (op_q == 5'b11000);

    always_comb begin
        last_cycle = 3'd0;
        if (is_slow) begin
            last_cycle = 3'd2;
        end else if (is_mul || is_jump || is_branch || (is_alu && is_shift)) begin
            last_cycle = 3'd1;
        end
    end

    assign last_beat   = (counter_q == 5'd31);
    assign mem_due     = (cycle_q == 3'd0) && (is_store || is_slow);
    assign new_is_fast = (instr_op_i == 5'b00000) && (instr_rs1_i == 5'b00100);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            counter_q <= 5'd0;
            cycle_q   <= 3'd0;
            op_q      <= 5'd0;
            f3_q      <= 3'd0;
            rs1_q     <= 5'd0;
            b25_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            cycle_q   <= cycle_d;
            op_q      <= op_d;
            f3_q      <= f3_d;
            rs1_q     <= rs1_d;
            b25_q     <= b25_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        cycle_d   = cycle_q;
        op_d      = op_q;
        f3_d      = f3_q;
        rs1_d     = rs1_q;
        b25_d     = b25_q;
        take_next = 1'b0;

        case (state_q)
            S_IDLE: begin
                take_next = 1'b1;
            end
            S_EXEC: begin
                counter_d = counter_q + 5'd1;
                if (last_beat) begin
                    if (mem_due) begin
                        state_d = S_MEM_WAIT;
                        cycle_d = is_slow ? 3'd1 : 3'd0;
                    end else if (cycle_q == last_cycle) begin
                        take_next = 1'b1;
                    end else begin
                        cycle_d = cycle_q + 3'd1;
                    end
                end
            end
            S_MEM_WAIT: begin
                counter_d = 5'd0;
                if (mem_ack_i) begin
                    state_d = S_MEM_SHIFT;
                end
            end
            S_MEM_SHIFT: begin
                counter_d = counter_q + 5'd1;
                if (last_beat) begin
                    if (is_store) begin
                        take_next = 1'b1;
                    end else begin
                        state_d = S_EXEC;
                        cycle_d = is_slow ? 3'd2 : 3'd0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Retirement and idle share one path: accept back-to-back or drop to IDLE.
        if (take_next) begin
            counter_d = 5'd0;
            cycle_d   = 3'd0;
            if (instr_valid_i) begin
                op_d    = instr_op_i;
                f3_d    = instr_f3_i;
                rs1_d   = instr_rs1_i;
                b25_d   = instr_b25_i;
                state_d = new_is_fast ? S_MEM_WAIT : S_EXEC;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    // Outputs depend on registered state only, never on instr_valid_i or mem_ack_i.
    always_comb begin
        busy_o           = (state_q != S_IDLE);
        mem_req_o        = (state_q == S_MEM_WAIT) || (state_q == S_MEM_SHIFT);
        shift_data_out_o = (state_q == S_MEM_SHIFT);
        mem_is_store_o   = mem_req_o && is_store;
        counter_o        = counter_q;
        cycle_o          = cycle_q;
        instr_ready_o    = ((state_q == S_EXEC) && last_beat && !mem_due && (cycle_q == last_cycle))
                        || ((state_q == S_MEM_SHIFT) && last_beat && is_store);
    end

endmodule

// File: tb/tb_p19_nanov_sequencer.sv
// Self-checking bench for p19_nanov_sequencer: directed table, hand sequences,
// and random traffic checked against a phase-list reference model.
module tb_p19_nanov_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic [4:0] instr_op;
    logic [2:0] instr_f3;
    logic [4:0] instr_rs1;
    logic       instr_b25;
    logic       mem_ack;
    logic       instr_ready;
    logic [4:0] counter;
    logic [2:0] cycle;
    logic       mem_req;
    logic       mem_is_store;
    logic       shift_data_out;
    logic       busy;

    int errors = 0;
    int checks = 0;

    p19_nanov_sequencer dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .instr_valid_i    (instr_valid),
        .instr_op_i       (instr_op),
        .instr_f3_i       (instr_f3),
        .instr_rs1_i      (instr_rs1),
        .instr_b25_i      (instr_b25),
        .mem_ack_i        (mem_ack),
        .instr_ready_o    (instr_ready),
        .counter_o        (counter),
        .cycle_o          (cycle),
        .mem_req_o        (mem_req),
        .mem_is_store_o   (mem_is_store),
        .shift_data_out_o (shift_data_out),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    // Reference model: an instruction is a list of phases (exec pass or memory phase).
    int  m_busy;
    int  nph;
    int  pidx;
    int  ph_mem [4];
    int  ph_cyc [4];
    int  beat;
    int  waiting;
    int  wcnt;
    int  m_store;

    function automatic int passes(input logic [4:0] op, input logic [2:0] f3, input logic b25);
        logic [1:0] f3lo;
        f3lo = f3[1:0];
        if (op == 5'b01100 && b25) return 2;
        if (op[2:0] == 3'b100) return (f3lo == 2'b01) ? 2 : 1;
        if (op == 5'b11011 || op == 5'b11001) return 2;
        if (op == 5'b11000) return 2;
        return 1;
    endfunction

    task automatic model_reset();
        m_busy = 0; nph = 0; pidx = 0; beat = 0; waiting = 0; wcnt = 0; m_store = 0;
    endtask

    task automatic model_accept(input logic [4:0] op, input logic [2:0] f3,
                                input logic [4:0] rs1, input logic b25);
        m_busy  = 1;
        pidx    = 0;
        beat    = 0;
        wcnt    = 0;
        m_store = (op == 5'b01000);
        if (op == 5'b01000) begin
            nph = 2; ph_mem[0] = 0; ph_cyc[0] = 0; ph_mem[1] = 1; ph_cyc[1] = 0;
        end else if (op == 5'b00000 && rs1 == 5'd4) begin
            nph = 2; ph_mem[0] = 1; ph_cyc[0] = 0; ph_mem[1] = 0; ph_cyc[1] = 0;
        end else if (op == 5'b00000) begin
            nph = 3; ph_mem[0] = 0; ph_cyc[0] = 0; ph_mem[1] = 1; ph_cyc[1] = 1;
            ph_mem[2] = 0; ph_cyc[2] = 2;
        end else begin
            nph = passes(op, f3, b25);
            for (int i = 0; i < nph; i++) begin
                ph_mem[i] = 0;
                ph_cyc[i] = i;
            end
        end
        waiting = ph_mem[0];
    endtask

    task automatic model_advance();
        pidx = pidx + 1;
        beat = 0;
        if (pidx == nph) begin
            m_busy = 0;
            if (instr_valid) model_accept(instr_op, instr_f3, instr_rs1, instr_b25);
        end else begin
            waiting = ph_mem[pidx];
            wcnt    = 0;
        end
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else if (m_busy == 0) begin
            if (instr_valid) model_accept(instr_op, instr_f3, instr_rs1, instr_b25);
        end else if (ph_mem[pidx] != 0 && waiting != 0) begin
            wcnt = wcnt + 1;
            if (mem_ack) waiting = 0;
        end else if (beat == 31) begin
            model_advance();
        end else begin
            beat = beat + 1;
        end
    endtask

    // Packed {instr_ready, counter, cycle, mem_req, mem_is_store, shift, busy}
    function automatic logic [12:0] model_out();
        logic       rdy;
        logic [4:0] cnt;
        logic [2:0] cyc;
        logic       req, st, sh;
        if (m_busy == 0) return 13'd0;
        cyc = 3'(ph_cyc[pidx]);
        if (ph_mem[pidx] == 0) begin
            cnt = 5'(beat); req = 1'b0; st = 1'b0; sh = 1'b0;
            rdy = (beat == 31) && (pidx == nph - 1);
        end else if (waiting != 0) begin
            cnt = 5'd0; req = 1'b1; st = 1'(m_store); sh = 1'b0; rdy = 1'b0;
        end else begin
            cnt = 5'(beat); req = 1'b1; st = 1'(m_store); sh = 1'b1;
            rdy = (beat == 31) && (pidx == nph - 1);
        end
        return {rdy, cnt, cyc, req, st, sh, 1'b1};
    endfunction

    function automatic logic [12:0] dut_out();
        return {instr_ready, counter, cycle, mem_req, mem_is_store, shift_data_out, busy};
    endfunction

    task automatic check_vec(input string name, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t act=%b exp=%b (rdy,cnt,cyc,req,st,sh,busy)", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_vec("trace", dut_out(), model_out());
    endtask

    task automatic drain();
        instr_valid = 1'b0;
        for (int i = 0; i < 400 && m_busy != 0; i++) begin
            mem_ack = 1'b1;
            tick();
        end
        check_int("drain_idle", int'(busy), 0);
    endtask

    typedef struct {
        string      name;
        logic [4:0] op;
        logic [2:0] f3;
        logic [4:0] rs1;
        logic       b25;
        int         ack_delay;
        int         exp_clocks;
        int         exp_max_cycle;
        int         exp_store;
    } vec_t;

    vec_t       vecs [12];
    logic [4:0] ops [10] = '{5'b00100, 5'b01100, 5'b11011, 5'b11001, 5'b11000,
                             5'b01101, 5'b00101, 5'b01000, 5'b00000, 5'b00011};

    initial begin
        int n, maxc, stseen, rdys, found;

        vecs[0]  = '{"addi",    5'b00100, 3'b000, 5'd1, 1'b0, 1,  32, 0, 0};
        vecs[1]  = '{"slli",    5'b00100, 3'b001, 5'd1, 1'b0, 1,  64, 1, 0};
        vecs[2]  = '{"srai",    5'b00100, 3'b101, 5'd1, 1'b0, 1,  64, 1, 0};
        vecs[3]  = '{"add",     5'b01100, 3'b000, 5'd1, 1'b0, 1,  32, 0, 0};
        vecs[4]  = '{"mul",     5'b01100, 3'b000, 5'd1, 1'b1, 1,  64, 1, 0};
        vecs[5]  = '{"lui",     5'b01101, 3'b000, 5'd0, 1'b0, 1,  32, 0, 0};
        vecs[6]  = '{"jal",     5'b11011, 3'b000, 5'd0, 1'b0, 1,  64, 1, 0};
        vecs[7]  = '{"beq",     5'b11000, 3'b000, 5'd3, 1'b0, 1,  64, 1, 0};
        vecs[8]  = '{"sw",      5'b01000, 3'b010, 5'd2, 1'b0, 1,  65, 0, 1};
        vecs[9]  = '{"lw_slow", 5'b00000, 3'b010, 5'd2, 1'b0, 5, 101, 2, 0};
        vecs[10] = '{"lw_fast", 5'b00000, 3'b010, 5'd4, 1'b0, 1,  65, 0, 0};
        vecs[11] = '{"fence",   5'b00011, 3'b000, 5'd0, 1'b0, 1,  32, 0, 0};

        rst = 1'b1; instr_valid = 1'b0; instr_op = 5'd0; instr_f3 = 3'd0;
        instr_rs1 = 5'd0; instr_b25 = 1'b0; mem_ack = 1'b0;
        model_reset();
        #1;
        check_vec("reset_state", dut_out(), 13'd0);
        tick();
        tick();
        rst = 1'b0;

        // Directed table: single instruction, count busy clocks to retirement.
        foreach (vecs[v]) begin
            instr_valid = 1'b1; instr_op = vecs[v].op; instr_f3 = vecs[v].f3;
            instr_rs1 = vecs[v].rs1; instr_b25 = vecs[v].b25;
            tick();
            instr_valid = 1'b0;
            n = 0; maxc = 0; stseen = 0;
            for (int k = 0; k < 300; k++) begin
                n++;
                if (int'(cycle) > maxc) maxc = int'(cycle);
                if (mem_is_store) stseen = 1;
                if (instr_ready) break;
                mem_ack = (m_busy != 0 && waiting != 0 && (wcnt + 1) >= vecs[v].ack_delay);
                tick();
            end
            mem_ack = 1'b0;
            check_int({vecs[v].name, "_clocks"}, n, vecs[v].exp_clocks);
            check_int({vecs[v].name, "_max_cycle"}, maxc, vecs[v].exp_max_cycle);
            check_int({vecs[v].name, "_store_seen"}, stseen, vecs[v].exp_store);
            tick();
            check_int({vecs[v].name, "_idle_after"}, int'(busy), 0);
        end

        // Back-to-back ADDI with instr_valid held high.
        instr_valid = 1'b1; instr_op = 5'b00100; instr_f3 = 3'b000; instr_b25 = 1'b0;
        tick();
        rdys = 0;
        for (int k = 0; k < 96; k++) begin
            if (instr_ready) rdys++;
            check_int("addi_b2b_cycle", int'(cycle), 0);
            tick();
        end
        check_int("addi_b2b_ready_count", rdys, 3);
        drain();

        // Asynchronous reset at counter 17 of MEM_SHIFT during a slow load.
        instr_valid = 1'b1; instr_op = 5'b00000; instr_rs1 = 5'd2; instr_f3 = 3'b010;
        tick();
        instr_valid = 1'b0;
        found = 0;
        for (int k = 0; k < 200; k++) begin
            if (m_busy != 0 && ph_mem[pidx] != 0 && waiting == 0 && beat == 17) begin
                found = 1;
                break;
            end
            mem_ack = (m_busy != 0 && waiting != 0 && wcnt >= 1);
            tick();
        end
        check_int("reach_shift_17", found, 1);
        check_int("shift_17_counter", int'(counter), 17);
        #2 rst = 1'b1;
        #1;
        check_vec("async_reset_outputs", dut_out(), 13'd0);
        model_reset();
        tick();
        rst = 1'b0;
        mem_ack = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        check_int("idle_after_reset", int'(busy), 0);
        mem_ack = 1'b0;

        // Random traffic against the model; fields change every clock.
        for (int k = 0; k < 4000; k++) begin
            instr_valid = ($urandom_range(0, 2) != 0);
            instr_op    = ops[$urandom_range(0, 9)];
            instr_f3    = 3'($urandom);
            instr_rs1   = ($urandom_range(0, 1) != 0) ? 5'd4 : 5'($urandom);
            instr_b25   = 1'($urandom);
            mem_ack     = ($urandom_range(0, 3) == 0);
            rst         = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
